omsp_spm_cmd_seq: RTL
=====================

# omsp_spm_cmd_seq

Sequencer that drives the protected-module (SPM) control array for protect/unprotect commands. It accepts one command at a time from the execution unit and pulses the array's update/enable strobes. It checks for an overlap or ID-exhaustion violation and, on a successful protect, streams the 128-bit module key from the key-derivation engine into the array as 16-bit words. It sits between the execution unit / key engine and the SPM control block, and is the only driver of `update_spm`, `enable_spm`, `write_key` and `key_in`.

## Interface
- `KEY_WORDS`, 8, number of 16-bit key words per protect (128-bit key).
- `TIMEOUT`, 255, maximum consecutive cycles in KEY without an accepted word (8-bit counter).
- `mclk` in 1: clock.
- `puc_rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: command request from the execution unit.
- `req_op` in 1: 1 = protect, 0 = unprotect; sampled on accept.
- `req_ready` out 1: high only in IDLE.
- `key_valid` in 1: key word available from the key engine.
- `key_word` in 16: key word, most-significant word first.
- `key_ready` out 1: high only in KEY.
- `violation` in 1: violation output of the SPM control block.
- `update_spm` out 1: update strobe to the SPM control block.
- `enable_spm` out 1: enable/disable qualifier to the SPM control block.
- `write_key` out 1: key write strobe.
- `key_in` out 16: key word to the SPM control block.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: 00 ok, 01 violation, 10 key timeout; 11 never driven.

## Operation
- FSM states: IDLE, UPDATE, CHECK, KEY, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_op` into `op`, clear the word counter and the timeout counter, and go to UPDATE.
- UPDATE:
  - `update_spm`=1, `enable_spm`=`op` for exactly this cycle.
  - Latch `violation` into sticky flag `viol`.
  - Go to CHECK.
- CHECK:
  - `viol` |= `violation`.
  - If `viol`, go to DONE with status 01.
  - Else if `op`=0, go to DONE with status 00.
  - Else go to KEY.
- KEY:
  - `key_ready`=1.
  - Each cycle with `key_valid`: accept `key_word`, increment the word counter, clear the timeout counter.
  - Word counter width is clog2(`KEY_WORDS`)+1. When the counter reaches `KEY_WORDS`, go to DONE with status 00.
  - Each cycle without `key_valid`, increment the timeout counter. When it reaches `TIMEOUT`, go to DONE with status 10. No teardown is issued; software must unprotect.
- DONE:
  - `done`=1, then go to IDLE.
  - `status` is written on entry to DONE and held until the next DONE.
- `req_valid` outside IDLE and `key_valid` outside KEY are ignored; no state change.
- `update_spm`, `enable_spm`, `write_key`, `key_in`, `done` and `status` are flop outputs. There are no combinational paths from inputs to outputs except `req_ready`, `key_ready` and `busy`, which are decoded from the state register.

## Timing
- Reset (async assert) forces the following immediately, mid-operation included:
  - State: IDLE.
  - Outputs: `update_spm`=0, `enable_spm`=0, `write_key`=0, `key_in`=0, `done`=0, `status`=00, `busy`=0.
  - Counters: 0.
  - An interrupted key load leaves a partially keyed module; no recovery is attempted.
- Accept at edge 0 → UPDATE cycle 1 → CHECK cycle 2.
  - Unprotect: `done` in cycle 3.
  - Protect: KEY from cycle 3.
- Key words: a word accepted at edge n produces `write_key`=1 with `key_in`=word during cycle n+1, one pulse per word, back-to-back allowed.
  - The last word's `write_key` coincides with the DONE cycle.
- Minimum protect latency with `key_valid` held high: accept → `done` = 3 + `KEY_WORDS` cycles (11 for the default).
- `violation` high in UPDATE or CHECK, even for a single cycle, yields status 01; no key words are accepted.
- `enable_spm` outside UPDATE is 0.
- Timeout counts consecutive idle KEY cycles only; a valid word on the cycle the counter would reach `TIMEOUT` is accepted and resets the count.

## Test plan
- Reset: hold `puc_rst_n`=0 → all outputs 0, `req_ready`=1; release, then `req_valid`=1, `req_op`=0 with `violation`=0 → `update_spm`=1 and `enable_spm`=0 in cycle 1, `done`=1 with `status`=00 in cycle 3.
- Protect, key 0x0001..0x0008 streamed with `key_valid` held high → eight `write_key` pulses with `key_in`=0x0001..0x0008 in order, `done` 11 cycles after accept, `status`=00.
- Protect with `violation`=1 only in the CHECK cycle → `key_ready` never asserted, `done` in cycle 3, `status`=01; a `req_valid` pulse during busy is ignored.
- Protect, 3 words delivered, then `key_valid`=0 for 255 cycles → exactly 3 `write_key` pulses, `done` with `status`=10, `req_ready`=1 the next cycle.
- Gapped key stream, one word every 200 cycles → no timeout, `status`=00. Assert `puc_rst_n`=0 after word 5 of a second protect → immediate IDLE, `write_key`=0, `status`=00.

Source files
------------

// File: rtl/omsp_spm_cmd_seq.sv
// Protect/unprotect command sequencer for the SPM control array.
// Pulses update/enable, checks for violations, and streams the module key as 16-bit words.
module omsp_spm_cmd_seq #(
    parameter int KEY_WORDS = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic        req_valid,
    input  logic        req_op,
    output logic        req_ready,
    input  logic        key_valid,
    input  logic [15:0] key_word,
    output logic        key_ready,
    input  logic        violation,
    output logic        update_spm,
    output logic        enable_spm,
    output logic        write_key,
    output logic [15:0] key_in,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status
);

    localparam int CNT_W = $clog2(KEY_WORDS) + 1;

    // Terminal values are compared before the increment so the exit decision is made
    // in the same cycle that the final word or idle cycle occurs.
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(KEY_WORDS - 1);
    localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_VIOL    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_CHECK,
        S_KEY,
        S_DONE
    } state_t;

    state_t           state;
    logic             op;
    logic             viol;
    logic [CNT_W-1:0] word_cnt;
    logic [7:0]       tmo_cnt;

    assign req_ready = (state == S_IDLE);
    assign key_ready = (state == S_KEY);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state      <= S_IDLE;
            op         <= 1'b0;
            viol       <= 1'b0;
            word_cnt   <= '0;
            tmo_cnt    <= '0;
            update_spm <= 1'b0;
            enable_spm <= 1'b0;
            write_key  <= 1'b0;
            key_in     <= '0;
            done       <= 1'b0;
            status     <= ST_OK;
        end else begin
            // NOTE: non-blocking defaults make every strobe a one-cycle pulse; a branch
            // below that sets one to 1 overrides this default for that single edge.
            update_spm <= 1'b0;
            enable_spm <= 1'b0;
            write_key  <= 1'b0;
            done       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op         <= req_op;
                        word_cnt   <= '0;
                        tmo_cnt    <= '0;
                        update_spm <= 1'b1;
                        enable_spm <= req_op;
                        state      <= S_UPDATE;
                    end
                end

                S_UPDATE: begin
                    viol  <= violation;
                    state <= S_CHECK;
                end

                S_CHECK: begin
                    if (viol || violation) begin
                        viol   <= 1'b1;
                        status <= ST_VIOL;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (!op) begin
                        status <= ST_OK;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_KEY;
                    end
                end

                S_KEY: begin
                    if (key_valid) begin
                        write_key <= 1'b1;
                        key_in    <= key_word;
                        word_cnt  <= word_cnt + 1'b1;
                        tmo_cnt   <= '0;
                        if (word_cnt == LAST_WORD) begin
                            status <= ST_OK;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        // No teardown on timeout: the module stays partially keyed.
                        if (tmo_cnt == TMO_LAST) begin
                            status <= ST_TIMEOUT;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
